wb_host_master: RTL

WB_HOST_MASTER -- requirements
Module: wb_host_master

---
 rtl/wb_host_pkg.sv | 15 +
 rtl/wb_host_master.sv | 121 ++++++++++++
 2 files changed

// File: rtl/wb_host_pkg.sv
// Shared types and constants for the Wishbone host-command master.
package wb_host_pkg;

  localparam int WB_AW           = 32;
  localparam int WB_DW           = 32;
  localparam int WB_SW           = 4;
  localparam int TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_host_master.sv
// Single-outstanding Wishbone classic master bridging a valid/ready command
// channel to one bus cycle and a valid/ready response, with an ack timeout.
module wb_host_master
  import wb_host_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [WB_AW-1:0] cmd_adr,
  input  logic [WB_DW-1:0] cmd_dat,
  input  logic [WB_SW-1:0] cmd_sel,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WB_DW-1:0] rsp_dat,
  output logic             rsp_err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [WB_SW-1:0] wbm_sel_o,
  output logic [WB_AW-1:0] wbm_adr_o,
  output logic [WB_DW-1:0] wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [WB_DW-1:0] wbm_dat_i
);

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_nxt;
  logic [7:0]       wait_cnt, wait_cnt_nxt;
  logic             we_q;
  logic [WB_AW-1:0] adr_q;
  logic [WB_DW-1:0] dat_q;
  logic [WB_SW-1:0] sel_q;
  logic [WB_DW-1:0] rsp_dat_q, rsp_dat_nxt;
  logic             rsp_err_q, rsp_err_nxt;
  logic             cmd_take;
  logic             rsp_load;
  logic             in_bus;
  logic             in_resp;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      wait_cnt  <= 8'd0;
      we_q      <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (cmd_take) begin
        we_q  <= cmd_we;
        adr_q <= cmd_adr;
        dat_q <= cmd_dat;
        sel_q <= cmd_sel;
      end
      if (rsp_load) begin
        rsp_dat_q <= rsp_dat_nxt;
        rsp_err_q <= rsp_err_nxt;
      end
    end
  end

  // Ack is tested before the wait limit so a last-cycle ack still completes cleanly.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    cmd_take     = 1'b0;
    rsp_load     = 1'b0;
    rsp_dat_nxt  = '0;
    rsp_err_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          cmd_take     = 1'b1;
          wait_cnt_nxt = 8'd0;
          state_nxt    = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          rsp_load    = 1'b1;
          rsp_dat_nxt = we_q ? '0 : wbm_dat_i;
          state_nxt   = ST_RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          rsp_load    = 1'b1;
          rsp_err_nxt = 1'b1;
          state_nxt   = ST_RESP;
        end else begin
          wait_cnt_nxt = wait_cnt + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign in_bus  = (state == ST_BUS);
  assign in_resp = (state == ST_RESP);

  assign cmd_ready = (state == ST_IDLE) && !wb_rst_i;
  assign wbm_cyc_o = in_bus;
  assign wbm_stb_o = in_bus;
  assign wbm_we_o  = in_bus && we_q;
  assign wbm_adr_o = in_bus ? adr_q : '0;
  assign wbm_sel_o = in_bus ? sel_q : '0;
  assign wbm_dat_o = (in_bus && we_q) ? dat_q : '0;
  assign rsp_valid = in_resp;
  assign rsp_dat   = in_resp ? rsp_dat_q : '0;
  assign rsp_err   = in_resp && rsp_err_q;

endmodule
